// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types and constants for the decode stage
//
// Purpose: instruction class encodings, opcode constants, MIPS field bit
//          positions, FSM state type and the decoded-field record.
// Ports:   none (package).
package decode_pkg;

    typedef enum logic [1:0] {
        ITYPE_R = 2'd0,
        ITYPE_I = 2'd1,
        ITYPE_J = 2'd2
    } itype_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int TGT_MSB = 25;

    // Storage occupancy: OUT/SKID valid bits encoded as a state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Everything except the XLEN-wide immediate, which is kept alongside.
    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [25:0] target;
        itype_e      itype;
    } fields_t;

    function automatic logic is_logic_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshake bundle
//
// Purpose: groups the instruction input stream and decoded output stream.
// Signals: in_valid/in_ready/in_inst (fetch side), out_valid/out_ready and
//          decoded fields opcode/rs/rt/rd/shamt/funct/imm/target/itype.
// Modports: master = fetch + consumer side, slave = decode stage.
interface decode_stage_if #(
    parameter int INST_W = 32,
    parameter int XLEN   = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [XLEN-1:0]   imm;
    logic [25:0]       target;
    logic [1:0]        itype;

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
               imm, target, itype
    );

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, opcode, rs, rt, rd, shamt, funct,
               imm, target, itype
    );
endinterface

// File: rtl/decode_stage_field_extract.sv
// rtl/decode_stage_field_extract.sv - combinational instruction field splitter
//
// Purpose: classifies an instruction as R/I/J, zeroes unused fields and
//          extends the 16-bit immediate to XLEN.
// Ports:   inst (in, INST_W), fields (out, fields_t), imm (out, XLEN).
module field_extract
    import decode_pkg::*;
#(
    parameter int INST_W         = 32,
    parameter int XLEN           = 32,
    parameter bit ZERO_EXT_LOGIC = 1'b1
) (
    input  logic [INST_W-1:0] inst,
    output fields_t           fields,
    output logic [XLEN-1:0]   imm
);

    logic [5:0]  op;
    logic [15:0] imm16;

    assign op    = inst[OPC_MSB:OPC_LSB];
    assign imm16 = inst[IMM_MSB:0];

    always_comb begin
        fields        = '0;
        imm           = '0;
        fields.opcode = op;
        fields.rs     = inst[RS_MSB:RS_LSB];
        fields.rt     = inst[RT_MSB:RT_LSB];
        if (op == OP_RTYPE) begin
            fields.itype = ITYPE_R;
            fields.rd    = inst[RD_MSB:RD_LSB];
            fields.shamt = inst[SH_MSB:SH_LSB];
            fields.funct = inst[FN_MSB:FN_LSB];
        end else if (op == OP_J || op == OP_JAL) begin
            fields.itype  = ITYPE_J;
            fields.target = inst[TGT_MSB:0];
        end else begin
            fields.itype = ITYPE_I;
            if (ZERO_EXT_LOGIC && is_logic_imm(op)) begin
                imm = XLEN'(imm16);
            end else begin
                imm = XLEN'(signed'(imm16));
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered instruction decode with 2-entry skid buffer
//
// Purpose: decodes fetched instructions into register fields, immediate and
//          jump target, buffering up to two so fetch may stall cleanly.
// Ports:   clk, rst (sync active-high), flush (drop held instructions),
//          bus (decode_stage_if.slave: fetch and execute handshakes + fields).
module decode_stage
    import decode_pkg::*;
#(
    parameter int INST_W         = 32,
    parameter int XLEN           = 32,
    parameter bit ZERO_EXT_LOGIC = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    decode_stage_if.slave   bus
);

    fields_t         dec_fields;
    logic [XLEN-1:0] dec_imm;

    // Decoding happens on the way in, so both registers hold finished fields.
    field_extract #(
        .INST_W         (INST_W),
        .XLEN           (XLEN),
        .ZERO_EXT_LOGIC (ZERO_EXT_LOGIC)
    ) u_extract (
        .inst   (bus.in_inst),
        .fields (dec_fields),
        .imm    (dec_imm)
    );

    state_e          state_q, state_d;
    logic            in_ready_q;
    logic            out_valid_q;
    fields_t         out_q, skid_q;
    logic [XLEN-1:0] out_imm_q, skid_imm_q;

    logic accept, drain;
    logic load_out_in, load_out_skid, load_skid, clear_out;

    assign accept = bus.in_valid & in_ready_q;
    assign drain  = out_valid_q & bus.out_ready;

    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        clear_out     = 1'b0;
        if (flush) begin
            state_d   = ST_EMPTY;
            clear_out = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        load_out_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        load_out_in = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_d   = ST_EMPTY;
                        clear_out = 1'b1;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can move us.
                    if (drain) begin
                        state_d       = ST_ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_EMPTY;
                    clear_out = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            out_imm_q  <= '0;
            skid_q     <= '0;
            skid_imm_q <= '0;
        end else begin
            if (clear_out) begin
                out_q     <= '0;
                out_imm_q <= '0;
            end else if (load_out_in) begin
                out_q     <= dec_fields;
                out_imm_q <= dec_imm;
            end else if (load_out_skid) begin
                out_q     <= skid_q;
                out_imm_q <= skid_imm_q;
            end
            if (load_skid) begin
                skid_q     <= dec_fields;
                skid_imm_q <= dec_imm;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.opcode    = out_q.opcode;
    assign bus.rs        = out_q.rs;
    assign bus.rt        = out_q.rt;
    assign bus.rd        = out_q.rd;
    assign bus.shamt     = out_q.shamt;
    assign bus.funct     = out_q.funct;
    assign bus.target    = out_q.target;
    assign bus.itype     = out_q.itype;
    assign bus.imm       = out_imm_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        out_ready;

    int checks_done = 0;
    int checks_failed = 0;

    localparam logic [31:0] INST_A = 32'h0109_5020; // add  rd=10 funct=0x20
    localparam logic [31:0] INST_B = 32'h2129_000A; // addi imm=0xA
    localparam logic [31:0] INST_C = 32'h0C00_0040; // jal  target=0x40

    always #5 clk = ~clk;

    decode_stage_if #(.INST_W(32), .XLEN(32)) bus0 ();
    decode_stage_if #(.INST_W(32), .XLEN(32)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_inst   = in_inst;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_inst   = in_inst;
    assign bus1.out_ready = out_ready;

    decode_stage #(.INST_W(32), .XLEN(32), .ZERO_EXT_LOGIC(1'b1)) u_dut_zext (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus0.slave)
    );

    decode_stage #(.INST_W(32), .XLEN(32), .ZERO_EXT_LOGIC(1'b0)) u_dut_sext (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus1.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_done++;
        if (got !== exp) begin
            checks_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b1;
        step(); step();
        check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus0.in_ready),  64'd1);
        check("rst_opcode",    64'(bus0.opcode),    64'd0);
        check("rst_imm",       64'(bus0.imm),       64'd0);
        check("rst_target",    64'(bus0.target),    64'd0);
        check("rst_itype",     64'(bus0.itype),     64'd0);
        rst = 1'b0;
        step();

        // R type
        in_valid = 1'b1; in_inst = 32'h012A_4020;
        step();
        in_valid = 1'b0;
        check("r_out_valid", 64'(bus0.out_valid), 64'd1);
        check("r_itype",     64'(bus0.itype),     64'd0);
        check("r_rs",        64'(bus0.rs),        64'd9);
        check("r_rt",        64'(bus0.rt),        64'd10);
        check("r_rd",        64'(bus0.rd),        64'd8);
        check("r_shamt",     64'(bus0.shamt),     64'd0);
        check("r_funct",     64'(bus0.funct),     64'h20);
        check("r_imm",       64'(bus0.imm),       64'd0);
        check("r_target",    64'(bus0.target),    64'd0);
        step();
        check("r_drained", 64'(bus0.out_valid), 64'd0);

        // addi then ori, back to back
        in_valid = 1'b1; in_inst = 32'h2108_FFFF;
        step();
        in_inst = 32'h3508_FFFF;
        check("addi_opcode", 64'(bus0.opcode), 64'h08);
        check("addi_itype",  64'(bus0.itype),  64'd1);
        check("addi_rs",     64'(bus0.rs),     64'd8);
        check("addi_rt",     64'(bus0.rt),     64'd8);
        check("addi_rd",     64'(bus0.rd),     64'd0);
        check("addi_imm_z",  64'(bus0.imm),    64'hFFFF_FFFF);
        check("addi_imm_s",  64'(bus1.imm),    64'hFFFF_FFFF);
        step();
        in_valid = 1'b0;
        check("ori_opcode", 64'(bus0.opcode),    64'h0D);
        check("ori_valid",  64'(bus0.out_valid), 64'd1);
        check("ori_imm_z",  64'(bus0.imm),       64'h0000_FFFF);
        check("ori_imm_s",  64'(bus1.imm),       64'hFFFF_FFFF);
        step();

        // J type
        in_valid = 1'b1; in_inst = 32'h0810_0000;
        step();
        in_valid = 1'b0;
        check("j_itype",  64'(bus0.itype),  64'd2);
        check("j_opcode", 64'(bus0.opcode), 64'd2);
        check("j_target", 64'(bus0.target), 64'h010_0000);
        check("j_rd",     64'(bus0.rd),     64'd0);
        check("j_funct",  64'(bus0.funct),  64'd0);
        check("j_imm",    64'(bus0.imm),    64'd0);
        step();

        // Stall: fill OUT and SKID, then release
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = INST_A;
        step();
        check("st_a_ready", 64'(bus0.in_ready), 64'd1);
        check("st_a_rd",    64'(bus0.rd),       64'd10);
        in_inst = INST_B;
        step();
        check("st_b_ready", 64'(bus0.in_ready), 64'd0);
        check("st_b_hold",  64'(bus0.rd),       64'd10);
        in_inst = INST_C;
        step();
        check("st_c_ready", 64'(bus0.in_ready), 64'd0);
        check("st_c_hold",  64'(bus0.rd),       64'd10);
        check("st_c_itype", 64'(bus0.itype),    64'd0);
        out_ready = 1'b1;
        step();
        check("dr_b_itype", 64'(bus0.itype), 64'd1);
        check("dr_b_imm",   64'(bus0.imm),   64'h0A);
        step();
        in_valid = 1'b0;
        check("dr_c_itype",  64'(bus0.itype),  64'd2);
        check("dr_c_target", 64'(bus0.target), 64'h40);
        step();
        check("dr_empty", 64'(bus0.out_valid), 64'd0);

        // Flush in ONE with an incoming instruction
        in_valid = 1'b1; in_inst = INST_A;
        step();
        in_inst = INST_B; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 64'(bus0.out_valid), 64'd0);
        check("fl_ready", 64'(bus0.in_ready),  64'd1);
        check("fl_rd",    64'(bus0.rd),        64'd0);
        step();
        check("fl_no_b", 64'(bus0.out_valid), 64'd0);

        // Reset while TWO
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = INST_A;
        step();
        in_inst = INST_B;
        step();
        check("rt_two", 64'(bus0.in_ready), 64'd0);
        rst = 1'b1; in_valid = 1'b0;
        step();
        check("rt_valid",  64'(bus0.out_valid), 64'd0);
        check("rt_ready",  64'(bus0.in_ready),  64'd1);
        check("rt_rd",     64'(bus0.rd),        64'd0);
        check("rt_funct",  64'(bus0.funct),     64'd0);
        check("rt_opcode", 64'(bus0.opcode),    64'd0);
        rst = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_inst = INST_C;
        step();
        in_valid = 1'b0;
        check("rt_c_valid",  64'(bus0.out_valid), 64'd1);
        check("rt_c_target", 64'(bus0.target),    64'h40);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction decode front-end; next generation of the combinational field splitter.
- Sits between instruction fetch and register-file/ALU control.
- Splits each instruction into fields and classifies it as R, I or J type.
- Produces an extended immediate and a jump target.
- Fetch side and execute side connect through valid/ready handshakes with a 2-entry skid buffer, so fetch can stall without losing instructions.

Parameters:
- INST_W, 32: instruction width; fields are located at the standard MIPS bit positions, so INST_W must be 32.
- XLEN, 32: width of the extended immediate output; must be at least 16.
- ZERO_EXT_LOGIC, 1: when 1, andi/ori/xori (opcodes 0x0C/0x0D/0x0E) zero-extend; otherwise all I-type immediates sign-extend.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held instructions (branch redirect)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode can accept an instruction
- in_inst  in  INST_W  instruction word
- out_valid  out  1  decoded fields valid
- out_ready  in  1  consumer accepts the decoded fields
- opcode  out  6  inst[31:26]
- rs  out  5  inst[25:21]
- rt  out  5  inst[20:16]
- rd  out  5  inst[15:11] for R type; 0 otherwise
- shamt  out  5  inst[10:6] for R type; 0 otherwise
- funct  out  6  inst[5:0] for R type; 0 otherwise
- imm  out  XLEN  extended inst[15:0] for I type; 0 otherwise
- target  out  26  inst[25:0] for J type; 0 otherwise
- itype  out  2  instruction class: 0 = R, 1 = I, 2 = J (3 unused)

Behaviour:
- Classification:
  - opcode 0 -> R type.
  - opcode 2 or 3 -> J type.
  - any other opcode -> I type.
- Field zeroing: fields not used by the class are driven to 0. Nothing is retained from a previous instruction.
- Immediate extension: sign-extend inst[15] to XLEN bits, except zero-extend when ZERO_EXT_LOGIC=1 and opcode is 0x0C, 0x0D or 0x0E.
- Storage: output register (OUT) plus one skid register (SKID). Each holds the fully decoded field set. Decoding happens before the write, so SKID-to-OUT is a plain copy.
- State machine, derived from the two valid bits:
  - EMPTY: OUT and SKID both empty.
  - ONE: OUT holds an instruction, SKID empty.
  - TWO: OUT and SKID both hold instructions.
- Handshake signals:
  - in_ready = (state != TWO), a register output.
  - Accept: in_valid & in_ready.
  - Drain: out_valid & out_ready.
- Transitions:
  - EMPTY + accept -> ONE; out_valid rises the cycle after accept (1-cycle latency).
  - ONE + accept + drain -> ONE; OUT loads the new instruction.
  - ONE + accept + no drain -> TWO; new instruction goes to SKID.
  - ONE + drain + no accept -> EMPTY.
  - TWO + drain -> ONE; SKID copies to OUT. No accept is possible in TWO.
- Throughput: one instruction per cycle sustained when out_ready is held at 1.
- Stall: while out_valid=1 and out_ready=0, all outputs hold stable.
- Reset:
  - state EMPTY, in_ready=1, out_valid=0.
  - Every field output is 0.
  - Reset asserted mid-operation discards OUT and SKID in the same edge.
- flush:
  - Next edge goes to EMPTY and clears the field outputs.
  - An accept in the flush cycle is discarded.
  - flush overrides drain and accept.
  - If rst and flush are asserted together, rst takes precedence; the result is identical.
- in_inst is sampled only on accept. Changes while in_ready=0 are ignored.

Decomposition:
- Shared package (decode_pkg) holds:
  - ITYPE_R/I/J encodings.
  - Opcode constants: OP_RTYPE=0, OP_J=2, OP_JAL=3, OP_ANDI=0x0C, OP_ORI=0x0D, OP_XORI=0x0E.
  - Field bit-position constants.
- One natural sub-module, field_extract: combinational inst -> {fields, itype, imm}. It is instantiated once, on in_inst, before the storage registers.

Test Plan:
1. Reset, then accept 0x012A4020 with out_ready=1 -> next cycle out_valid=1, itype=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20, imm=0, target=0.
2. Accept 0x2108FFFF (addi), then 0x3508FFFF (ori), with ZERO_EXT_LOGIC=1 -> addi: opcode 0x08, itype=1, rs=8, rt=8, rd=0, imm=0xFFFFFFFF. ori: imm=0x0000FFFF. With ZERO_EXT_LOGIC=0 -> ori imm=0xFFFFFFFF.
3. Accept 0x08100000 -> itype=2, opcode 2, target=0x0100000, rd=funct=imm=0.
4. Hold out_ready=0 and stream 3 instructions A,B,C with in_valid=1 -> A and B accepted, in_ready=0 from the cycle after B, outputs hold A. Raise out_ready -> outputs A, B, C in order, each exactly once.
5. Streaming with out_ready=1: assert flush while in state ONE with in_valid=1 -> next cycle out_valid=0, in_ready=1. The flush-cycle instruction never appears at the output.
6. In state TWO, assert rst -> next cycle out_valid=0, in_ready=1, all fields 0. The next accepted instruction appears with 1-cycle latency.
